// File: rtl/dmio_arbiter.sv
// -----------------------------------------------------------------------------
// dmio_arbiter
//   Shares the single data-memory / IO bus between two requesters.
//   Port 0 is the processor datapath and port 1 is the loader/debug port.
//   Accesses are serialised through a four-state sequencer:
//     IDLE -> ACCESS -> WAIT (READ_LAT cycles) -> DONE -> IDLE
//   The sequencer latches the granted command, pulses the write strobe for one
//   cycle, and waits for the bus read latency. It then returns read data
//   together with a one-cycle acknowledge.
//
//   Optional feature macro: DMIO_ARB_RR_EN
//     defined   : round-robin arbitration (last-granted port loses priority)
//     undefined : fixed priority, port 0 wins collisions
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   reqN, weN, addrN, wdataN  requester N command (level request, held to ackN)
//   rdataN, ackN            requester N read data (valid with ackN), done pulse
//   mem_addr, mem_wdata, mem_wr  bus command (registered)
//   mem_rdata               bus read data, valid READ_LAT cycles after address
//   busy                    a transaction is in progress
//   owner                   port index of the current / last grant
// -----------------------------------------------------------------------------
module dmio_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 64,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] LAT_L = 3'(READ_LAT);

    state_t            r_state;
    state_t            w_next_state;
    logic [2:0]        r_cnt;
    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_wr;
    logic              r_owner;
    logic              r_busy;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_grant;
    logic              w_gnt_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_to_done;

`ifdef DMIO_ARB_RR_EN
    // Priority pointer: 0 means port 0 wins a collision, 1 means port 1 wins.
    logic r_prio;

    // Round-robin pointer: the port just granted drops to lowest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_grant) begin
            r_prio <= ~w_gnt_sel;
        end else begin
            r_prio <= r_prio;
        end
    end
`endif

    // Arbitration and selection of the granted command.
    always_comb begin
        w_grant   = req0 | req1;
        w_gnt_sel = 1'b0;
`ifdef DMIO_ARB_RR_EN
        if (req0 && req1) begin
            w_gnt_sel = r_prio;
        end else if (req1) begin
            w_gnt_sel = 1'b1;
        end else begin
            w_gnt_sel = 1'b0;
        end
`else
        if (req0) begin
            w_gnt_sel = 1'b0;
        end else if (req1) begin
            w_gnt_sel = 1'b1;
        end else begin
            w_gnt_sel = 1'b0;
        end
`endif
        if (w_gnt_sel) begin
            w_sel_we    = we1;
            w_sel_addr  = addr1;
            w_sel_wdata = wdata1;
        end else begin
            w_sel_we    = we0;
            w_sel_addr  = addr0;
            w_sel_wdata = wdata0;
        end
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next_state = ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (READ_LAT > 0) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            ST_WAIT: begin
                // <= rather than == so a corrupted zero count cannot trap the FSM
                if (r_cnt <= 3'd1) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        w_to_done = (r_state != ST_DONE) && (w_next_state == ST_DONE);
    end

    // Sequencer state, command latch, bus drive and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_cmd_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wr    <= 1'b0;
            r_owner     <= 1'b0;
            r_busy      <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_busy   <= (w_next_state != ST_IDLE);
            r_mem_wr <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The bus registers double as the command latch, so they
                    // hold their last values while idle.
                    if (w_grant) begin
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_cmd_we    <= w_sel_we;
                        r_owner     <= w_gnt_sel;
                        r_mem_wr    <= w_sel_we;
                    end else begin
                        r_cmd_we    <= r_cmd_we;
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= LAT_L;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
            // Response is registered on entry to DONE, so ack and read data
            // are both visible for the whole DONE cycle.
            if (w_to_done) begin
                if (r_owner) begin
                    r_ack1 <= 1'b1;
                    if (!r_cmd_we) begin
                        r_rdata1 <= mem_rdata;
                    end
                end else begin
                    r_ack0 <= 1'b1;
                    if (!r_cmd_we) begin
                        r_rdata0 <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wr    = r_mem_wr;
    assign busy      = r_busy;
    assign owner     = r_owner;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;

endmodule

// File: doc/dmio_arbiter.md
Name: dmio_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single data-memory/IO bus (4096 x 64-bit RAM plus memory-mapped LED/switch region) between two requesters.
- Port 0 is the processor datapath; port 1 is the loader/debug port.
- Serialises accesses, times the write strobe, waits the memory read latency, and returns read data with a one-cycle acknowledge.

Parameters:
- ADDR_W, 13, bus address width; bit ADDR_W-1 selects the IO region (1 = LEDs/switches, 0 = RAM).
- DATA_W, 64, data width.
- READ_LAT, 1, cycles from address presentation to valid mem_rdata (range 0-7).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  port 0 access request; level, held until ack0.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- rdata0  output  DATA_W  port 0 read data; registered, valid when ack0 = 1.
- ack0  output  1  port 0 completion pulse.
- req1, we1, addr1, wdata1, rdata1, ack1: same as port 0, for port 1.
- mem_addr  output  ADDR_W  to the memory/IO bus address.
- mem_wdata  output  DATA_W  to the bus write data.
- mem_wr  output  1  to the bus write strobe.
- mem_rdata  input  DATA_W  from the bus read data.
- busy  output  1  transaction in progress (state != IDLE).
- owner  output  1  index of the granted port for the current or last transaction.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, mem_wr = 0, mem_addr = 0, mem_wdata = 0.
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0, busy = 0, owner = 0, priority pointer = port 0.
  - Reset mid-transaction aborts it immediately; mem_wr drops without a clock; no ack is issued.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any reqN = 1, grant per the arbitration policy.
  - Latch addrN, wdataN and weN into the internal command register; set owner; go to ACCESS.
  - No request: stay in IDLE, bus outputs hold their last values, mem_wr = 0.
- ACCESS (1 cycle):
  - mem_addr/mem_wdata driven from the latched command.
  - mem_wr = latched we, for exactly this one cycle.
  - Latency counter loads READ_LAT.
  - Next state is WAIT if READ_LAT > 0, else DONE.
- WAIT:
  - Counter decrements each cycle; address held stable, mem_wr = 0.
  - Go to DONE when the counter reaches 1.
- DONE (1 cycle):
  - For a read, rdata[owner] <= mem_rdata. For a write, rdata is unchanged.
  - ack[owner] = 1 for this cycle only; go to IDLE.
- Timing:
  - Total latency from req sampled in IDLE to ack = READ_LAT + 2 cycles.
  - Throughput is one access per READ_LAT + 3 cycles, because IDLE takes one cycle between transactions.
- Handshake rules:
  - A requester drops req on the edge at which it samples ack = 1. A req still high in the following IDLE cycle is a new access.
  - Changing addr/wdata/we while req is held has no effect after the grant, since the command is latched in IDLE.
  - Dropping req before ack does not cancel the transaction: a write still commits and ack still pulses.
  - The non-granted port waits with no ack and its rdata unchanged.
- Arbitration (default, fixed priority):
  - Port 0 wins when both ports request in the same IDLE cycle.
  - Port 1 can starve under continuous port-0 traffic; this is acceptable.
- IO region: addresses with bit ADDR_W-1 = 1 are passed through unchanged.
  - Writes update the LED register.
  - Reads return the switch value zero-extended by the bus; the arbiter does not decode it.
- Only one transaction is ever outstanding. mem_wr never asserts outside ACCESS.

Optional Feature:
- Macro: DMIO_ARB_RR_EN.
- Defined: round-robin arbitration.
  - The priority pointer updates on each grant so the last-granted port gets the lowest priority.
  - With both ports continuously requesting, grants alternate 0,1,0,1.
  - The pointer resets to port 0.
- Undefined: fixed priority as above; the pointer logic is not synthesised.

Test Plan:
- Reset: hold rst_n = 0 with req0 = 1 -> all outputs 0 and busy = 0. Assert rst_n = 0 during ACCESS of a write -> mem_wr falls asynchronously and no ack follows.
- Single write then read, READ_LAT = 1: port 0 writes 0x0123456789ABCDEF to address 0x005 -> mem_wr high exactly one cycle, ack0 three cycles after req0 sampled. A later read of 0x005 -> rdata0 = 0x0123456789ABCDEF with ack0.
- Collision, fixed priority: req0 and req1 rise in the same cycle -> port 0 served first (owner = 0), then port 1. ack0 and ack1 never coincide.
- Collision with DMIO_ARB_RR_EN defined, both ports holding req for 4 transactions -> owner sequence 0,1,0,1.
- IO path: port 1 writes 0xA5 to address 0x1000 -> mem_addr = 0x1000, mem_wr pulse. Port 1 reads 0x1000 with the bus returning 0x3C -> rdata1 = 0x000000000000003C.
- Early release: port 0 drops req0 in the cycle after the grant of a write to 0x010 -> write still occurs and ack0 still pulses once. With READ_LAT = 0 -> ack arrives two cycles after the grant sample.
